// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry and the write-back entry type shared by the queue.
package regfile_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS = 16;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// wb_match: youngest-match search over occupied queue entries for pending-write bypass.
module wb_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t              ents [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [3:0]             count,
  input  logic [REG_ADDR_W-1:0]  q_src,
  output logic                   hit,
  output logic [REG_DATA_W-1:0]  hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (4'(i) < count && ents[idx].dst == q_src) begin
        hit = 1'b1;
        hit_data = ents[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order register write-back buffer with drain-on-free-port and pending-write bypass.
module wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic [REG_DATA_W-1:0] in_data,
  input  logic                  hold,
  output logic [REG_ADDR_W-1:0] dst,
  output logic [REG_DATA_W-1:0] WD,
  output logic                  WE,
  input  logic [REG_ADDR_W-1:0] q_src,
  output logic                  hit,
  output logic [REG_DATA_W-1:0] hit_data,
  output logic [3:0]            count
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic empty, push;
  always_comb begin
    empty = count == 4'd0;
    WE = !empty && !hold;
    in_ready = count < 4'(DEPTH) || !hold;
    push = in_valid && in_ready;
    dst = empty ? '0 : mem[head].dst;
    WD = empty ? '0 : mem[head].data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (WE) head <= head + 1'b1;
      count <= count + 4'(push) - 4'(WE);
    end
  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk)
    if (push) mem[tail] <= '{dst: in_dst, data: in_data};
  wb_match #(.DEPTH(DEPTH)) u_match (
    .ents(mem),
    .head(head),
    .count(count),
    .q_src(q_src),
    .hit(hit),
    .hit_data(hit_data)
  );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized scoreboard bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
  logic clk = 0, rst = 1, in_valid = 0, hold = 0, in_ready, WE, hit;
  logic [3:0] in_dst = 0, q_src = 0, dst, count;
  logic [15:0] in_data = 0, WD, hit_data;
  int tests = 0, fails = 0;
  logic [19:0] pend [$];
  logic [19:0] exp_q [$];
  localparam int DEPTH = 4;
  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst),
    .in_data(in_data), .hold(hold), .dst(dst), .WD(WD), .WE(WE), .q_src(q_src),
    .hit(hit), .hit_data(hit_data), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // Monitor: every register-file write must be the next expected one in arrival order.
  always @(negedge clk)
    if (!rst && WE === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write: unexpected dst=%0h WD=%0h at %0t", dst, WD, $time);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({dst, WD} !== e) begin
          fails++;
          $display("FAIL write: got %0h/%0h, expected %0h/%0h at %0t", dst, WD, e[19:16], e[15:0], $time);
        end
      end
    end
  bit accepted = 1;
  task automatic cycle(input logic v, input logic [3:0] d, input logic [15:0] dat,
                       input logic h, input logic [3:0] qs);
    logic exp_we, exp_rdy, exp_hit;
    logic [15:0] exp_hd;
    @(posedge clk);
    #1;
    in_valid = v; in_dst = d; in_data = dat; hold = h; q_src = qs;
    #1;
    exp_we = pend.size() != 0 && !h;
    exp_rdy = pend.size() < DEPTH || !h;
    exp_hit = 0;
    exp_hd = 0;
    foreach (pend[i]) if (pend[i][19:16] == qs) begin exp_hit = 1; exp_hd = pend[i][15:0]; end
    chk("count", 32'(count), 32'(pend.size()));
    chk("WE", 32'(WE), 32'(exp_we));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("dst", 32'(dst), pend.size() != 0 ? 32'(pend[0][19:16]) : 0);
    chk("WD", 32'(WD), pend.size() != 0 ? 32'(pend[0][15:0]) : 0);
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("hit_data", 32'(hit_data), 32'(exp_hd));
    if (exp_we) void'(pend.pop_front());
    accepted = !(v && exp_rdy) ? !v : 1;
    if (v && exp_rdy) begin
      pend.push_back({d, dat});
      exp_q.push_back({d, dat});
    end
  endtask
  initial begin
    logic v, h;
    logic [3:0] d;
    logic [15:0] dat;
    #3;
    chk("rst count", 32'(count), 0);
    chk("rst WE", 32'(WE), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst dst/WD", 32'({dst, WD}), 0);
    chk("rst hit", 32'({hit, hit_data}), 0);
    #10 rst = 0;
    cycle(1, 3, 16'h00AA, 0, 3);
    cycle(0, 0, 0, 0, 3);
    cycle(0, 0, 0, 0, 3);
    for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 16'(i), 1, 0);
    cycle(1, 5, 16'h0005, 1, 4);
    cycle(1, 5, 16'h0005, 0, 4);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 5);
    cycle(1, 2, 16'h0011, 1, 2);
    cycle(1, 2, 16'h0022, 1, 2);
    cycle(0, 0, 0, 1, 2);
    cycle(0, 0, 0, 1, 7);
    cycle(0, 0, 0, 1, 7);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 2);
    for (int i = 0; i < 10; i++) cycle(1, 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
    chk("wrap drained", 32'(exp_q.size()), 0);
    for (int i = 0; i < 3; i++) cycle(1, 4'(8 + i), 16'(16'h100 + i), 1, 9);
    @(posedge clk);
    #3 rst = 1; in_valid = 0;
    #1;
    chk("async count", 32'(count), 0);
    chk("async WE", 32'(WE), 0);
    chk("async hit", 32'({hit, hit_data}), 0);
    chk("async in_ready", 32'(in_ready), 1);
    pend.delete();
    exp_q.delete();
    @(posedge clk);
    #3 rst = 0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 9);
    for (int i = 0; i < 400; i++) begin
      if (accepted) begin
        v = ($urandom_range(0, 3) != 0);
        d = 4'($urandom);
        dat = 16'($urandom);
      end
      h = ($urandom_range(0, 2) == 0);
      cycle(v, d, dat, h, 4'($urandom));
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
    chk("final drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  producer offers a register write result.
REQ-005 SHALL have port in_ready  output  1  queue can accept the offered result this cycle.
REQ-006 SHALL have port in_dst  input  4  destination register index of offered result.
REQ-007 SHALL have port in_data  input  16  data of offered result.
REQ-008 SHALL have port hold  input  1  register write port unavailable this cycle; suppresses draining.
REQ-009 SHALL have port dst  output  4  write index to register file.
REQ-010 SHALL have port WD  output  16  write data to register file.
REQ-011 SHALL have port WE  output  1  write enable to register file.
REQ-012 SHALL have port q_src  input  4  lookup index for pending-write bypass.
REQ-013 SHALL have port hit  output  1  a queued write to q_src is pending.
REQ-014 SHALL have port hit_data  output  16  data of youngest queued write to q_src.
REQ-015 SHALL have port count  output  4  number of occupied entries, 0..DEPTH.

Function
REQ-016 SHALL accept an entry at a posedge where in_valid && in_ready, appending {in_dst, in_data} at the tail.
REQ-017 SHALL drive WE = (count != 0) && !hold, combinationally.
REQ-018 SHALL drive dst/WD from the head entry when count != 0, else 4'd0/16'd0.
REQ-019 SHALL pop the head at every posedge where WE = 1 (the register file captures it on the same edge).
REQ-020 SHALL drive in_ready = (count < DEPTH) || !hold; full with drain this cycle still accepts.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-022 SHALL have 1-cycle minimum latency: entry pushed at edge N is presented with WE at edge N+1 if hold = 0; no combinational in->WD path.
REQ-023 SHALL write entries in strict arrival order, including repeated writes to the same dst (last one wins in register file).
REQ-024 SHALL drive hit = 1 iff any occupied entry has dst == q_src, combinationally, including the head being popped this cycle.
REQ-025 SHALL drive hit_data from the youngest matching entry; 16'd0 when hit = 0.
REQ-026 SHALL NOT include the in_* port in the hit lookup (only stored entries).
REQ-027 SHALL wrap head/tail pointers modulo DEPTH without loss or duplication.
REQ-028 SHALL ignore in_valid when in_ready = 0 (producer holds data stable until accepted).
REQ-029 SHALL keep all outputs stable while hold = 1 and in_valid = 0.

Reset
REQ-030 SHALL, while rst = 1, asynchronously force count = 0, head = tail = 0, WE = 0, dst = 0, WD = 0, hit = 0, hit_data = 0, in_ready = 1.
REQ-031 SHALL discard all pending entries on reset mid-operation; no WE pulse during or on the edge after rst deasserts.
REQ-032 SHALL NOT require reset of the entry storage array.

Structure
REQ-033 SHALL take REG_ADDR_W = 4, REG_DATA_W = 16, NUM_REGS = 16 from shared package regfile_pkg.
REQ-034 SHALL place youngest-match search (age-ordered priority over occupied entries) in sub-module wb_match.
REQ-035 SHALL connect dst/WD/WE directly to the register file write port with no glue logic.

Verification
REQ-036 Push (3, 16'h00AA), hold = 0 -> next cycle WE = 1, dst = 3, WD = 16'h00AA; following cycle count = 0, WE = 0.
REQ-037 hold = 1, push 4 entries (r1=1, r2=2, r3=3, r4=4) -> count = 4, in_ready = 0; release hold -> WE for 4 consecutive cycles with dst 1,2,3,4 in order.
REQ-038 Queue full, hold = 0, push r5=5 same cycle -> accepted, count stays 4, r5 written fifth.
REQ-039 hold = 1, queue r2=16'h0011 then r2=16'h0022, q_src = 2 -> hit = 1, hit_data = 16'h0022; q_src = 7 -> hit = 0, hit_data = 0.
REQ-040 Push 10 entries through DEPTH = 4 with random hold -> all 10 written exactly once, in order (pointer wrap check).
REQ-041 Assert rst asynchronously with count = 3 -> WE, count, hit drop to 0 before next edge; no writes after release until new push.
